// File: rtl/sorter_bench_pkg.sv
// Shared types and constants for the merge-sorter stimulus generator / checker.
package sorter_bench_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_INTERLEAVE = 2'd0;
   localparam logic [1:0] MODE_BLOCK      = 2'd1;
   localparam logic [1:0] MODE_DUP        = 2'd2;

   // All-ones key of width keyw, right-aligned in 64 bits (keyw <= 64).
   function automatic logic [63:0] sentinel_key(input int unsigned keyw);
      return {64{1'b1}} >> (64 - keyw);
   endfunction

endpackage

// File: rtl/sorter_stim_lane.sv
// One leaf channel: holds the presented record, counts accepts and switches to
// the sentinel once the channel's finite stream has been consumed.
module sorter_stim_lane
   import sorter_bench_pkg::*;
#(
   parameter int CH       = 0,
   parameter int W_LOG    = 9,
   parameter int DATW     = 64,
   parameter int KEYW     = 32,
   parameter int NREC_LOG = 8
) (
   input  logic            CLK,
   input  logic            RST_X,
   input  logic            load,
   input  logic [1:0]      mode,
   input  logic            en,
   output logic [DATW-1:0] rec
);

   localparam int N = 1 << NREC_LOG;
   localparam logic [63:0]              SENT_W  = sentinel_key(KEYW);
   localparam logic [KEYW-1:0]          SENT    = SENT_W[KEYW-1:0];
   localparam logic [KEYW-1:0]          ONE     = KEYW'(1);
   localparam logic [NREC_LOG-1:0]      CNT_ONE = NREC_LOG'(1);
   localparam logic [NREC_LOG-1:0]      CNT_MAX = NREC_LOG'(N - 1);
   localparam logic [DATW-KEYW-1:0]     IDX     = (DATW-KEYW)'(CH);

   logic [NREC_LOG-1:0] cnt;
   logic                sent;

   // Key of the c-th record of this channel (c counts from 0).
   function automatic logic [KEYW-1:0] key_of(input logic [1:0] m, input logic [NREC_LOG-1:0] c);
      logic [KEYW-1:0] c1;
      c1 = KEYW'(c) + ONE;
      case (m)
         MODE_BLOCK: key_of = KEYW'(CH * N) + c1;
         MODE_DUP:   key_of = c1;
         default:    key_of = (c1 << W_LOG) - KEYW'(CH);
      endcase
   endfunction

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         cnt  <= '0;
         sent <= 1'b0;
         rec  <= '0;
      end else if (load) begin
         cnt  <= '0;
         sent <= 1'b0;
         rec  <= {IDX, key_of(mode, '0)};
      end else if (en) begin
         if (sent || (cnt == CNT_MAX)) begin
            sent <= 1'b1;
            rec  <= {IDX, SENT};
         end else begin
            cnt <= cnt + CNT_ONE;
            rec <= {IDX, key_of(mode, cnt + CNT_ONE)};
         end
      end
   end

endmodule

// File: rtl/sorter_stim_chk.sv
// Leaf stimulus generator and merged-output checker for the merge sorter tree.
// Optional idle watchdog with TIMEOUT port: define SORTER_STIM_WATCHDOG_EN.
//
//   state   | meaning
//   IDLE    | after reset, waiting for START
//   RUN     | lanes feed the tree, checker consumes DOT
//   DONE    | TOTAL records checked (or watchdog fired); held until START
module sorter_stim_chk
   import sorter_bench_pkg::*;
#(
   parameter int W_LOG    = 9,
   parameter int DATW     = 64,
   parameter int KEYW     = 32,
   parameter int NREC_LOG = 8,
   parameter int TO_LOG   = 16
) (
   input  logic                          CLK,
   input  logic                          RST_X,
   input  logic                          START,
   input  logic [1:0]                    MODE,
   output logic [(DATW<<W_LOG)-1:0]      DIN,
   output logic [(1<<W_LOG)-1:0]         DINEN,
   input  logic [(1<<W_LOG)-1:0]         FUL,
   input  logic [DATW-1:0]               DOT,
   input  logic                          DOTEN,
   output logic                          BUSY,
   output logic                          DONE,
   output logic                          ERR,
   output logic [15:0]                   ERR_CNT,
   output logic [W_LOG+NREC_LOG:0]       RCV_CNT,
`ifdef SORTER_STIM_WATCHDOG_EN
   output logic                          TIMEOUT,
`endif
   output logic                          OUT
);

   localparam int N_CH  = 1 << W_LOG;
   localparam int N     = 1 << NREC_LOG;
   localparam int TOTAL = N << W_LOG;
   localparam int CW    = W_LOG + NREC_LOG + 1;
   localparam logic [63:0]     SENT_W = sentinel_key(KEYW);
   localparam logic [KEYW-1:0] SENT   = SENT_W[KEYW-1:0];
   localparam logic [KEYW-1:0] ONE    = KEYW'(1);
   localparam logic [CW-1:0]   TOT_C  = CW'(TOTAL);

   state_t          state, state_nxt;
   logic [1:0]      mode_q, lane_mode;
   logic [KEYW-1:0] exp_key, prev_key, key;
   logic            start_ok, chk_en, bad, err_inc, wd_hit;

   assign start_ok  = START && (state != ST_RUN);
   assign lane_mode = start_ok ? MODE : mode_q;
   assign key       = DOT[KEYW-1:0];
   assign chk_en    = (state == ST_RUN) && DOTEN && (RCV_CNT < TOT_C);
   assign bad       = (mode_q == MODE_DUP) ?
                      ((key < prev_key) || (key > KEYW'(N)) || (key == SENT)) :
                      (key != exp_key);
   assign err_inc   = (chk_en && bad) || wd_hit;

`ifdef SORTER_STIM_WATCHDOG_EN
   logic [TO_LOG-1:0] idle_cnt;

   assign wd_hit = (state == ST_RUN) && !DOTEN && !START && (idle_cnt == {TO_LOG{1'b1}});

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         idle_cnt <= '0;
         TIMEOUT  <= 1'b0;
      end else begin
         if (DOTEN || START) idle_cnt <= '0;
         else if (state == ST_RUN) idle_cnt <= idle_cnt + TO_LOG'(1);
         if (start_ok) TIMEOUT <= 1'b0;
         else if (wd_hit) TIMEOUT <= 1'b1;
      end
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (START) state_nxt = ST_RUN;
         ST_RUN:           if ((RCV_CNT == TOT_C) || wd_hit) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      BUSY  = (state == ST_RUN);
      DONE  = (state == ST_DONE);
      DINEN = {N_CH{state == ST_RUN}} & ~FUL;
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         mode_q   <= MODE_INTERLEAVE;
         exp_key  <= '0;
         prev_key <= '0;
         RCV_CNT  <= '0;
         ERR      <= 1'b0;
         ERR_CNT  <= '0;
      end else if (start_ok) begin
         mode_q   <= MODE;
         exp_key  <= ONE;
         prev_key <= '0;
         RCV_CNT  <= '0;
         ERR      <= 1'b0;
         ERR_CNT  <= '0;
      end else begin
         if (chk_en) begin
            RCV_CNT  <= RCV_CNT + CW'(1);
            exp_key  <= exp_key + ONE;
            prev_key <= key;
         end
         if (err_inc) begin
            ERR <= 1'b1;
            if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
         end
      end
   end

   // Parity sink kept for the timing harness; samples every valid beat.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X)     OUT <= 1'b0;
      else if (DOTEN) OUT <= ^DOT;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      sorter_stim_lane #(
         .CH       (i),
         .W_LOG    (W_LOG),
         .DATW     (DATW),
         .KEYW     (KEYW),
         .NREC_LOG (NREC_LOG)
      ) u_lane (
         .CLK   (CLK),
         .RST_X (RST_X),
         .load  (start_ok),
         .mode  (lane_mode),
         .en    (DINEN[i]),
         .rec   (DIN[DATW*i +: DATW])
      );
   end

endmodule

// File: tb/tb_sorter_stim_chk.sv
// Bench for sorter_stim_chk with a 4-way behavioural merge tree in place of the sorter.
module tb_sorter_stim_chk;

   logic         clk = 1'b0;
   logic         rst_x;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] din;
   logic [3:0]   dinen;
   logic [3:0]   ful;
   logic [63:0]  dot;
   logic         doten;
   logic         busy, done, err, out;
   logic [15:0]  err_cnt;
   logic [4:0]   rcv_cnt;
`ifdef SORTER_STIM_WATCHDOG_EN
   logic         timeout;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] qm [4][32];
   int          qh [4];
   int          qt [4];
   logic [31:0] out_keys [32];
   logic [63:0] last_dot;
   logic [3:0]  ful_force;
   logic        merge_en;
   int          n_out, corrupt_idx, cyc, last_cyc, done_cyc, rcv16_cyc, busy_n;
   logic [31:0] corrupt_key;

   always #5 clk = ~clk;

   sorter_stim_chk #(
      .W_LOG    (2),
      .DATW     (64),
      .KEYW     (32),
      .NREC_LOG (2),
      .TO_LOG   (4)
   ) dut (
      .CLK     (clk),
      .RST_X   (rst_x),
      .START   (start),
      .MODE    (mode),
      .DIN     (din),
      .DINEN   (dinen),
      .FUL     (ful),
      .DOT     (dot),
      .DOTEN   (doten),
      .BUSY    (busy),
      .DONE    (done),
      .ERR     (err),
      .ERR_CNT (err_cnt),
      .RCV_CNT (rcv_cnt),
`ifdef SORTER_STIM_WATCHDOG_EN
      .TIMEOUT (timeout),
`endif
      .OUT     (out)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [63:0] r);
      qm[i][qt[i] % 32] = r;
      qt[i]++;
   endtask

   // One clock of the tree model: pop the smallest head, drive FUL, capture accepted leaves.
   task automatic tick();
      int          best;
      logic [63:0] r;
      logic        all_ne;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rcv_cnt == 5'd16 && rcv16_cyc < 0) rcv16_cyc = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy) busy_n++;
      doten  = 1'b0;
      all_ne = 1'b1;
      for (int i = 0; i < 4; i++) if (qt[i] == qh[i]) all_ne = 1'b0;
      if (merge_en && all_ne) begin
         best = 0;
         for (int i = 1; i < 4; i++)
            if (qm[i][qh[i] % 32][31:0] < qm[best][qh[best] % 32][31:0]) best = i;
         r = qm[best][qh[best] % 32];
         qh[best]++;
         if (n_out < 32) out_keys[n_out] = r[31:0];
         if (n_out == corrupt_idx) r[31:0] = corrupt_key;
         n_out++;
         if (n_out == 16) last_cyc = cyc;
         dot      = r;
         doten    = 1'b1;
         last_dot = r;
      end
      for (int i = 0; i < 4; i++) ful[i] = ful_force[i] | ((qt[i] - qh[i]) >= 16);
      #1;
      for (int i = 0; i < 4; i++) if (dinen[i]) push(i, din[64*i +: 64]);
   endtask

   task automatic start_run(input logic [1:0] m);
      for (int i = 0; i < 4; i++) begin qh[i] = 0; qt[i] = 0; end
      n_out     = 0;
      done_cyc  = -1;
      rcv16_cyc = -1;
      last_cyc  = -1;
      busy_n    = 0;
      doten     = 1'b0;
      mode      = m;
      start     = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done_cyc < 0 && k < 300) begin tick(); k++; end
      chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
   endtask

   task automatic check_keys(input string tag, input logic [1:0] m);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s_key%0d", tag, i), 64'(out_keys[i]),
             (m == 2'd2) ? 64'(i / 4 + 1) : 64'(i + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_x       = 1'b0;
      start       = 1'b0;
      mode        = 2'd0;
      ful         = 4'b0;
      ful_force   = 4'b0;
      dot         = '0;
      doten       = 1'b0;
      merge_en    = 1'b0;
      corrupt_idx = -1;
      corrupt_key = '0;
      cyc         = 0;
      n_out       = 0;
      done_cyc    = -1;
      rcv16_cyc   = -1;
      last_cyc    = -1;
      busy_n      = 0;
      last_dot    = '0;
      for (int i = 0; i < 4; i++) begin qh[i] = 0; qt[i] = 0; end

      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_rcv_cnt", 64'(rcv_cnt), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_dinen", 64'(dinen), 64'd0);
      chk("rst_din", 64'(|din), 64'd0);
`ifdef SORTER_STIM_WATCHDOG_EN
      chk("rst_timeout", 64'(timeout), 64'd0);
`endif
      @(negedge clk);
      rst_x = 1'b1;
      tick();

      // Valid beats in IDLE only feed the parity sink.
      dot = 64'h1; doten = 1'b1;
      tick();
      chk("idle_out_odd", 64'(out), 64'd1);
      chk("idle_rcv_cnt", 64'(rcv_cnt), 64'd0);
      dot = 64'h3; doten = 1'b1;
      tick();
      chk("idle_out_even", 64'(out), 64'd0);
      chk("idle_err", 64'(err), 64'd0);

      // Interleave mode, clean run.
      merge_en = 1'b1;
      start_run(2'd0);
      wait_done("m0");
      chk("m0_rcv16_cyc", 64'(rcv16_cyc), 64'(last_cyc + 1));
      chk("m0_done_cyc", 64'(done_cyc), 64'(last_cyc + 2));
      chk("m0_busy", 64'(busy), 64'd0);
      chk("m0_err", 64'(err), 64'd0);
      check_keys("m0", 2'd0);
      for (int k = 0; k < 5; k++) tick();
      merge_en = 1'b0;
      tick();
      chk("m0_post_rcv_cnt", 64'(rcv_cnt), 64'd16);
      chk("m0_post_err", 64'(err), 64'd0);
      chk("m0_out_parity", 64'(out), 64'(^last_dot));
      chk("m0_lane0_sentinel", din[63:0], {32'd0, 32'hFFFF_FFFF});
      chk("m0_lane3_sentinel", din[255:192], {32'd3, 32'hFFFF_FFFF});

      // Block mode with the 5th output key corrupted to 6.
      merge_en    = 1'b1;
      corrupt_idx = 4;
      corrupt_key = 32'd6;
      start_run(2'd1);
      wait_done("m1");
      chk("m1_err", 64'(err), 64'd1);
      chk("m1_err_cnt", 64'(err_cnt), 64'd1);
      chk("m1_rcv_cnt", 64'(rcv_cnt), 64'd16);
      check_keys("m1", 2'd1);

      // Duplicate mode, clean then with a 3 injected after a 4.
      corrupt_idx = -1;
      start_run(2'd2);
      wait_done("m2");
      chk("m2_err", 64'(err), 64'd0);
      chk("m2_err_cnt", 64'(err_cnt), 64'd0);
      check_keys("m2", 2'd2);
      corrupt_idx = 13;
      corrupt_key = 32'd3;
      start_run(2'd2);
      wait_done("m2b");
      chk("m2b_err", 64'(err), 64'd1);
      chk("m2b_err_cnt", 64'(err_cnt), 64'd1);
      corrupt_idx = -1;

      // Back-pressure on lane 2 only.
      ful_force = 4'b0100;
      start_run(2'd0);
      for (int k = 0; k < 10; k++) tick();
      chk("ful_dinen2_low", 64'(dinen[2]), 64'd0);
      chk("ful_din2_hold", din[191:128], {32'd2, 32'd2});
      chk("ful_dinen0_high", 64'(dinen[0]), 64'd1);
      chk("ful_din0_adv", din[63:0], {32'd0, 32'hFFFF_FFFF});
      chk("ful_din3_adv", din[255:192], {32'd3, 32'hFFFF_FFFF});
      ful_force = 4'b0;
      ful[2]    = 1'b0;
      #1;
      chk("ful_dinen2_back", 64'(dinen[2]), 64'd1);
      if (dinen[2]) push(2, din[191:128]);
      wait_done("ful");
      chk("ful_err", 64'(err), 64'd0);
      chk("ful_rcv_cnt", 64'(rcv_cnt), 64'd16);
      check_keys("ful", 2'd0);

      // Asynchronous reset in the middle of a run.
      start_run(2'd0);
      begin
         int k;
         k = 0;
         while (rcv_cnt != 5'd7 && k < 100) begin tick(); k++; end
      end
      chk("mid_rcv_cnt7", 64'(rcv_cnt), 64'd7);
      #2;
      rst_x = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_dinen", 64'(dinen), 64'd0);
      chk("arst_rcv_cnt", 64'(rcv_cnt), 64'd0);
      chk("arst_din", 64'(|din), 64'd0);
      @(negedge clk);
      rst_x = 1'b1;
      tick();
      start_run(2'd0);
      wait_done("arst");
      chk("arst_run_err", 64'(err), 64'd0);
      chk("arst_run_rcv_cnt", 64'(rcv_cnt), 64'd16);
      check_keys("arst", 2'd0);

`ifdef SORTER_STIM_WATCHDOG_EN
      // Tree withholds output entirely.
      merge_en = 1'b0;
      start_run(2'd0);
      begin
         int k;
         k = 0;
         while (done_cyc < 0 && k < 60) begin tick(); k++; end
      end
      chk("wd_busy_cycles", 64'(busy_n), 64'd16);
      chk("wd_timeout", 64'(timeout), 64'd1);
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_err_cnt", 64'(err_cnt), 64'd1);
      chk("wd_done", 64'(done), 64'd1);
      merge_en = 1'b1;
      start_run(2'd0);
      tick();
      chk("wd_timeout_clr", 64'(timeout), 64'd0);
      wait_done("wd_rerun");
      chk("wd_rerun_err", 64'(err), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
